led_out_device: RTL and testbench
=================================

// Module: led_out_device
// PURPOSE
//  Output-side peripheral on the CPU I/O bus, opposite in direction to the key input path.
//  Accepts 32-bit command words, using the same {opcode[31:24], arg[23:8], mask[3:0]} framing
//  the key event words use. Drives four LED/output pins in static, blink or timed-pulse mode.
//  Raises a one-cycle irq when a timed pulse expires. Provides a status word for readback.
// PARAMETERS
//  PRESCALE  50000  clk cycles per mode tick (>=2); all blink/pulse timing counts ticks
// PORTS
//  clk     in   1   system clock, single clock domain
//  rst     in   1   reset, asynchronous, active-low (0 = reset)
//  we      in   1   command strobe; in[31:0] is sampled on the clk edge where we=1
//  in      in   32  command word
//  ack     out  1   one-cycle pulse the cycle after an accepted command
//  err     out  1   one-cycle pulse (with ack) when the opcode is unknown
//  irq     out  1   one-cycle pulse when any channel's pulse expires
//  led     out  4   output pins, bit n = channel n, active-high
//  out     out  32  status {8'd2, 8'd0, 8'd0, pend[3:0], led[3:0]}
// BEHAVIOUR
//  Reset (rst=0, async): led=0, ack=0, err=0, irq=0, out={8'd2,24'd0}.
//   Reset also zeroes the prescaler, all modes (OFF) and all channel counters.
//   Reset mid-pulse or mid-blink aborts with no irq.
//  Prescaler: 0..PRESCALE-1 counter; tick=1 for one clk when counter==PRESCALE-1, then wraps to 0.
//  Per-channel state: mode {OFF, ON, BLINK, PULSE}, cnt[7:0] and per[7:0].
//   led[n]=1 in ON; toggles in BLINK; =1 in PULSE; =0 in OFF.
//  Command decode (we=1), mask=in[3:0], A=in[15:8]. Only masked channels change.
//   8'd0 NOP: nothing changes; ack.
//   8'd1 SET: mode=ON if in[16] else OFF.
//   8'd2 BLINK: per=cnt=max(A,1); led[n]=1.
//   8'd3 PULSE: if A==0, mode=OFF and irq next cycle (zero-length pulse);
//        otherwise mode=PULSE, cnt=A, led[n]=1.
//   other opcodes: no state change; ack=1 and err=1.
//  Latency: led, ack, err and out are updated on the edge that samples we.
//   They are visible 1 cycle later. ack always follows a we, including NOP and bad opcodes.
//  On tick:
//   BLINK with cnt==1 -> toggle led, cnt=per; otherwise cnt--.
//   PULSE with cnt==1 -> mode=OFF, led=0, flag expiry; otherwise cnt--.
//   ON and OFF are unaffected.
//  irq is registered: it is 1 in the cycle after any channel expires, or after a zero-length PULSE.
//   Several channels expiring at once give a single irq pulse.
//  pend[n]=1 while channel n is in PULSE.
//  Simultaneous we and tick: for masked channels the command wins and that tick is discarded.
//   Unmasked channels process the tick normally.
//  Re-issuing PULSE to a pulsing channel restarts cnt with no irq for the aborted pulse.
//   SET or BLINK to a pulsing channel cancels it silently.
//  Back-to-back we on consecutive cycles: every word is executed and gets its own ack.
// TESTING
//  (PRESCALE=4)
//  1 Reset/SET: release rst; we with {8'd1,7'd0,1'b1,8'd0,4'd0,4'b0101}.
//    -> led=4'b0101 one cycle later, ack=1 for one cycle, err=0, out=32'h0200_0005.
//  2 BLINK: A=3 on ch0.
//    -> led[0]=1 immediately, then toggles every 3 ticks (12 clk).
//    -> other channels are unaffected.
//  3 PULSE: A=2 on ch2 and ch3.
//    -> pend=4'b1100, led[3:2]=11.
//    -> After 2 ticks both drop to 0, a single irq pulse follows, and pend returns to 0.
//  4 Edge cases:
//    -> PULSE with A=0 on ch1: irq one cycle after ack, led[1]=0.
//    -> Opcode 8'h7F: ack=1, err=1, led unchanged.
//  5 Collision and abort:
//    -> A BLINK command on the same edge as a tick reloads per/cnt, and that tick is ignored.
//    -> rst=0 mid-pulse: everything clears, and no irq is raised after rst is released.

Source files
------------

// File: rtl/led_out_device_if.sv
// CPU I/O bus bundle for the LED output peripheral: command strobe/word in,
// ack/err/irq pulses, pin state and status word out.
interface led_out_device_if;
   logic        we;
   logic [31:0] in;
   logic        ack;
   logic        err;
   logic        irq;
   logic [3:0]  led;
   logic [31:0] out;

   modport master (
      output we,
      output in,
      input  ack,
      input  err,
      input  irq,
      input  led,
      input  out
   );

   modport slave (
      input  we,
      input  in,
      output ack,
      output err,
      output irq,
      output led,
      output out
   );
endinterface

// File: rtl/led_out_device.sv
// Four-channel LED driver on the CPU I/O bus: static, blink and timed-pulse modes
// paced by a shared prescaler tick, with an irq pulse on pulse expiry.
module led_out_device #(
   parameter int unsigned PRESCALE = 50000
) (
   input logic              clk,
   input logic              rst,
   led_out_device_if.slave  bus
);

   typedef enum logic [1:0] {ModeOff, ModeOn, ModeBlink, ModePulse} mode_e;

   localparam int unsigned PsW     = $clog2(PRESCALE);
   localparam logic [7:0]  OpNop   = 8'd0;
   localparam logic [7:0]  OpSet   = 8'd1;
   localparam logic [7:0]  OpBlink = 8'd2;
   localparam logic [7:0]  OpPulse = 8'd3;

   logic [PsW-1:0] ps_q;
   mode_e          mode_q [4];
   logic [7:0]     cnt_q  [4];
   logic [7:0]     per_q  [4];
   logic [3:0]     led_q;
   logic           ack_q, err_q, exp_q, irq_q;

   logic       tick, known, zero_pulse;
   logic [7:0] opcode, arg, arg_min1;
   logic [3:0] mask, cmd_hit, expire, pend;
   logic       unused;

   always_comb begin
      opcode     = bus.in[31:24];
      arg        = bus.in[15:8];
      mask       = bus.in[3:0];
      arg_min1   = (arg == 8'd0) ? 8'd1 : arg;
      tick       = (ps_q == PsW'(PRESCALE - 1));
      known      = (opcode == OpSet) || (opcode == OpBlink) || (opcode == OpPulse);
      zero_pulse = bus.we && (opcode == OpPulse) && (arg == 8'd0) && (mask != 4'd0);
      cmd_hit    = '0;
      pend       = '0;
      expire     = '0;
      for (int n = 0; n < 4; n++) begin
         // A command to a channel swallows any tick landing on the same edge.
         cmd_hit[n] = bus.we && known && mask[n];
         pend[n]    = (mode_q[n] == ModePulse);
         expire[n]  = tick && !cmd_hit[n] && pend[n] && (cnt_q[n] == 8'd1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ps_q  <= '0;
         led_q <= '0;
         ack_q <= 1'b0;
         err_q <= 1'b0;
         exp_q <= 1'b0;
         irq_q <= 1'b0;
         for (int n = 0; n < 4; n++) begin
            mode_q[n] <= ModeOff;
            cnt_q[n]  <= '0;
            per_q[n]  <= '0;
         end
      end else begin
         ps_q  <= tick ? '0 : ps_q + PsW'(1);
         ack_q <= bus.we;
         err_q <= bus.we && !known && (opcode != OpNop);
         // Expiry is flagged on the tick edge; irq follows one cycle later.
         exp_q <= (|expire) || zero_pulse;
         irq_q <= exp_q;
         for (int n = 0; n < 4; n++) begin
            if (cmd_hit[n]) begin
               unique case (opcode)
                  OpSet: begin
                     mode_q[n] <= bus.in[16] ? ModeOn : ModeOff;
                     led_q[n]  <= bus.in[16];
                  end
                  OpBlink: begin
                     mode_q[n] <= ModeBlink;
                     per_q[n]  <= arg_min1;
                     cnt_q[n]  <= arg_min1;
                     led_q[n]  <= 1'b1;
                  end
                  OpPulse: begin
                     if (arg == 8'd0) begin
                        mode_q[n] <= ModeOff;
                        led_q[n]  <= 1'b0;
                     end else begin
                        mode_q[n] <= ModePulse;
                        cnt_q[n]  <= arg;
                        led_q[n]  <= 1'b1;
                     end
                  end
                  default: ;
               endcase
            end else if (tick) begin
               case (mode_q[n])
                  ModeBlink: begin
                     if (cnt_q[n] == 8'd1) begin
                        led_q[n] <= ~led_q[n];
                        cnt_q[n] <= per_q[n];
                     end else begin
                        cnt_q[n] <= cnt_q[n] - 8'd1;
                     end
                  end
                  ModePulse: begin
                     if (cnt_q[n] == 8'd1) begin
                        mode_q[n] <= ModeOff;
                        led_q[n]  <= 1'b0;
                        cnt_q[n]  <= '0;
                     end else begin
                        cnt_q[n] <= cnt_q[n] - 8'd1;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign unused  = ^{bus.in[23:17], bus.in[7:4]};
   assign bus.ack = ack_q;
   assign bus.err = err_q;
   assign bus.irq = irq_q;
   assign bus.led = led_q;
   assign bus.out = {8'd2, 8'd0, 8'd0, pend, led_q};

endmodule

// File: tb/tb_led_out_device.sv
// Scoreboard bench for led_out_device at PRESCALE=4: commands push expected
// {err, status} entries, a monitor pops and compares on every ack.
module tb_led_out_device;

   typedef struct packed {
      logic        err;
      logic [31:0] out;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   int   irq_cnt = 0;
   int   ack_idx = 0;
   exp_t sb[$];

   led_out_device_if bus ();

   led_out_device #(.PRESCALE(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Counts posedges since reset release; ticks land on edges where cyc % 4 == 0.
   always @(posedge clk) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, required %h (cyc %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [31:0] cmd(input logic [7:0] op, input logic [7:0] a,
                                       input logic on, input logic [3:0] m);
      return {op, 7'd0, on, a, 4'd0, m};
   endfunction

   // Monitor: pops one expectation per ack and counts irq pulses.
   always @(negedge clk) begin
      if (rst) begin
         if (bus.irq === 1'b1) irq_cnt++;
         if (bus.ack === 1'b1) begin
            if (sb.size() == 0) begin
               n_chk++;
               $display("FAIL ack_unexpected: ack seen with 0 expected entries, required 1");
            end else begin
               exp_t e;
               e = sb.pop_front();
               check($sformatf("ack%0d_err", ack_idx), {31'd0, bus.err}, {31'd0, e.err});
               check($sformatf("ack%0d_out", ack_idx), bus.out, e.out);
            end
            ack_idx++;
         end
      end
   end

   task automatic send(input logic [31:0] w, input logic e, input logic [31:0] o);
      sb.push_back('{err: e, out: o});
      @(negedge clk);
      bus.we = 1'b1;
      bus.in = w;
      @(negedge clk);
      bus.we = 1'b0;
      bus.in = '0;
   endtask

   task automatic wait_led(input int idx, input logic v, input int max,
                           output int t, output logic ok);
      ok = 1'b0;
      t  = 0;
      for (int i = 0; i < max && !ok; i++) begin
         @(negedge clk);
         if (bus.led[idx] === v) begin
            ok = 1'b1;
            t  = cyc;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1);
   end

   initial begin
      int   t1, t2, t3, i0, c_edge;
      logic ok;
      bus.we = 1'b0;
      bus.in = '0;

      // Reset state
      @(negedge clk);
      check("rst_led", {28'd0, bus.led}, 32'd0);
      check("rst_ack", {31'd0, bus.ack}, 32'd0);
      check("rst_err", {31'd0, bus.err}, 32'd0);
      check("rst_irq", {31'd0, bus.irq}, 32'd0);
      check("rst_out", bus.out, 32'h0200_0000);
      @(negedge clk);
      rst = 1'b1;

      // SET on ch0/ch2
      send(cmd(8'd1, 8'd0, 1'b1, 4'b0101), 1'b0, 32'h0200_0005);

      // BLINK A=3 on ch0: toggle every 3 ticks = 12 clk
      send(cmd(8'd1, 8'd0, 1'b0, 4'b0001), 1'b0, 32'h0200_0004);
      send(cmd(8'd2, 8'd3, 1'b0, 4'b0001), 1'b0, 32'h0200_0005);
      wait_led(0, 1'b0, 20, t1, ok);
      check("blink_first_toggle", {31'd0, ok}, 32'd1);
      wait_led(0, 1'b1, 20, t2, ok);
      check("blink_second_toggle", {31'd0, ok}, 32'd1);
      check("blink_period_a", t2 - t1, 32'd12);
      wait_led(0, 1'b0, 20, t3, ok);
      check("blink_period_b", t3 - t2, 32'd12);
      check("blink_other_ch", {28'd0, bus.led}, 32'h4);
      send(cmd(8'd1, 8'd0, 1'b0, 4'b0001), 1'b0, 32'h0200_0004);

      // PULSE A=2 on ch2/ch3: one irq after both expire
      i0 = irq_cnt;
      send(cmd(8'd3, 8'd2, 1'b0, 4'b1100), 1'b0, 32'h0200_00CC);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (bus.out[7:4] == 4'd0) ok = 1'b1;
      end
      check("pulse_expired", {31'd0, ok}, 32'd1);
      check("pulse_led_off", {28'd0, bus.led}, 32'd0);
      check("pulse_irq_not_yet", {31'd0, bus.irq}, 32'd0);
      repeat (3) @(negedge clk);
      check("pulse_irq_count", irq_cnt - i0, 32'd1);

      // Zero-length PULSE on ch1: irq the cycle after ack
      send(cmd(8'd3, 8'd0, 1'b0, 4'b0010), 1'b0, 32'h0200_0000);
      check("zp_irq_with_ack", {31'd0, bus.irq}, 32'd0);
      @(negedge clk);
      check("zp_irq_after_ack", {31'd0, bus.irq}, 32'd1);
      @(negedge clk);
      check("zp_irq_single", {31'd0, bus.irq}, 32'd0);

      // Bad opcode and NOP leave state alone
      send(cmd(8'd1, 8'd0, 1'b1, 4'b0011), 1'b0, 32'h0200_0003);
      send(cmd(8'h7F, 8'd5, 1'b1, 4'b1111), 1'b1, 32'h0200_0003);
      send(cmd(8'd0, 8'd5, 1'b1, 4'b1111), 1'b0, 32'h0200_0003);

      // Back-to-back commands
      sb.push_back('{err: 1'b0, out: 32'h0200_0002});
      sb.push_back('{err: 1'b0, out: 32'h0200_000A});
      @(negedge clk);
      bus.we = 1'b1;
      bus.in = cmd(8'd1, 8'd0, 1'b0, 4'b0001);
      @(negedge clk);
      bus.in = cmd(8'd1, 8'd0, 1'b1, 4'b1000);
      @(negedge clk);
      bus.we = 1'b0;
      bus.in = '0;

      // BLINK A=2 landing on a tick edge: tick ignored, toggle 8 clk later
      send(cmd(8'd1, 8'd0, 1'b0, 4'b1111), 1'b0, 32'h0200_0000);
      while (cyc % 4 != 3) @(negedge clk);
      sb.push_back('{err: 1'b0, out: 32'h0200_0001});
      bus.we = 1'b1;
      bus.in = cmd(8'd2, 8'd2, 1'b0, 4'b0001);
      @(negedge clk);
      bus.we = 1'b0;
      bus.in = '0;
      c_edge = cyc;
      while (cyc < c_edge + 7) @(negedge clk);
      check("collide_hold", {31'd0, bus.led[0]}, 32'd1);
      @(negedge clk);
      check("collide_toggle", {31'd0, bus.led[0]}, 32'd0);

      // Reset mid-pulse: no irq afterwards
      send(cmd(8'd1, 8'd0, 1'b0, 4'b0001), 1'b0, 32'h0200_0000);
      send(cmd(8'd3, 8'd3, 1'b0, 4'b0100), 1'b0, 32'h0200_0044);
      i0 = irq_cnt;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("abort_led", {28'd0, bus.led}, 32'd0);
      check("abort_out", bus.out, 32'h0200_0000);
      @(negedge clk);
      rst = 1'b1;
      repeat (30) @(negedge clk);
      check("abort_no_irq", irq_cnt - i0, 32'd0);
      check("abort_out_after", bus.out, 32'h0200_0000);

      check("sb_drained", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
